// File: rtl/led_frame_tx.sv
// WS2812-style strip transmitter: renders ball/paddle pixels from a snapshot of the
// positions and shifts NUM_LEDS x 24 GRB bits MSB-first, followed by the latch low period.
module led_frame_tx #(
  parameter int          NUM_LEDS     = 300,
  parameter int          TBIT         = 125,
  parameter int          T0H          = 40,
  parameter int          T1H          = 80,
  parameter int          TRESET       = 5000,
  parameter logic [23:0] BALL_COLOR   = 24'h00FF00,
  parameter logic [23:0] PADDLE_COLOR = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR     = 24'h000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] ball,
  input  logic [8:0] player1,
  input  logic [8:0] player2,
  input  logic [8:0] player3,
  output logic       dout,
  output logic       busy,
  output logic       frame_done
);

  localparam int LW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int TW = (TBIT > 1) ? $clog2(TBIT) : 1;
  localparam int RW = (TRESET > 1) ? $clog2(TRESET) : 1;
  // Common compare width so out-of-range 9-bit indices can never alias a real LED.
  localparam int CW = (LW > 9) ? LW : 9;

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

  state_t          r_state;
  logic [LW-1:0]   r_led;
  logic [4:0]      r_bit;
  logic [TW-1:0]   r_tmr;
  logic [RW-1:0]   r_lat;
  logic [8:0]      r_ball;
  logic [8:0]      r_p1;
  logic [8:0]      r_p2;
  logic [8:0]      r_p3;
  logic            r_dout;
  logic            r_busy;
  logic            r_done;

  logic            w_tmr_wrap;
  logic            w_bit_wrap;
  logic            w_last_led;
  logic            w_lat_end;
  logic [TW-1:0]   w_nxt_tmr;
  logic [4:0]      w_nxt_bit;
  logic [LW-1:0]   w_nxt_led;
  logic [23:0]     w_color;
  int              w_thigh;
  logic            w_nxt_dout;

  function automatic logic [23:0] pixel_color(input logic [LW-1:0] idx,
                                              input logic [8:0] b, input logic [8:0] p1,
                                              input logic [8:0] p2, input logic [8:0] p3);
    logic [CW-1:0] x;
    x = CW'(idx);
    if (x == CW'(b))
      return BALL_COLOR;
    else if (x == CW'(p1) || x == CW'(p2) || x == CW'(p3))
      return PADDLE_COLOR;
    else
      return BG_COLOR;
  endfunction

  assign w_tmr_wrap = (r_tmr == TW'(TBIT - 1));
  assign w_bit_wrap = (r_bit == 5'd0);
  assign w_last_led = (r_led == LW'(NUM_LEDS - 1));
  assign w_lat_end  = (r_lat == RW'(TRESET - 1));

  // Look one cycle ahead so dout can be registered for the bit position it will show.
  assign w_nxt_tmr  = w_tmr_wrap ? '0 : r_tmr + 1'b1;
  assign w_nxt_bit  = w_tmr_wrap ? (w_bit_wrap ? 5'd23 : r_bit - 5'd1) : r_bit;
  assign w_nxt_led  = (w_tmr_wrap && w_bit_wrap) ? r_led + 1'b1 : r_led;
  assign w_color    = pixel_color(w_nxt_led, r_ball, r_p1, r_p2, r_p3);
  assign w_thigh    = w_color[w_nxt_bit] ? T1H : T0H;
  assign w_nxt_dout = (int'(w_nxt_tmr) < w_thigh);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_led   <= '0;
      r_bit   <= '0;
      r_tmr   <= '0;
      r_lat   <= '0;
      r_dout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_dout <= 1'b0;
          r_busy <= 1'b0;
          if (start) begin
            r_ball  <= ball;
            r_p1    <= player1;
            r_p2    <= player2;
            r_p3    <= player3;
            r_led   <= '0;
            r_bit   <= 5'd23;
            r_tmr   <= '0;
            // Every bit opens with a high phase, so the first level is 1 regardless of colour.
            r_dout  <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (w_tmr_wrap && w_bit_wrap && w_last_led) begin
            r_dout  <= 1'b0;
            r_lat   <= '0;
            r_state <= LATCH;
          end else begin
            r_tmr  <= w_nxt_tmr;
            r_bit  <= w_nxt_bit;
            r_led  <= w_nxt_led;
            r_dout <= w_nxt_dout;
          end
        end
        LATCH: begin
          r_dout <= 1'b0;
          if (w_lat_end) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_lat   <= '0;
            r_state <= IDLE;
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end
        default: begin
          r_dout  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign dout       = r_dout;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule

// File: tb/tb_led_frame_tx.sv
// Bench for led_frame_tx on a 4-LED strip: decodes the serial stream by high-time and
// compares every pixel against a reference built directly from the drawing rules.
module tb_led_frame_tx;

  localparam int          N      = 4;
  localparam int          TBIT   = 10;
  localparam int          T0H    = 3;
  localparam int          T1H    = 7;
  localparam int          TRESET = 20;
  localparam logic [23:0] BALLC  = 24'hF0000F;
  localparam logic [23:0] PADC   = 24'h000001;
  localparam logic [23:0] BGC    = 24'h000000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [8:0] ball = '0;
  logic [8:0] player1 = '0;
  logic [8:0] player2 = '0;
  logic [8:0] player3 = '0;
  logic       dout;
  logic       busy;
  logic       frame_done;

  int n_checks = 0;
  int n_errors = 0;

  led_frame_tx #(
    .NUM_LEDS(N), .TBIT(TBIT), .T0H(T0H), .T1H(T1H), .TRESET(TRESET),
    .BALL_COLOR(BALLC), .PADDLE_COLOR(PADC), .BG_COLOR(BGC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ball(ball),
    .player1(player1), .player2(player2), .player3(player3),
    .dout(dout), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] ref_pixel(input int idx, input int b, input int p1,
                                            input int p2, input int p3);
    if (idx == b) return BALLC;
    if (idx == p1 || idx == p2 || idx == p3) return PADC;
    return BGC;
  endfunction

  // Runs one frame from IDLE; disturb changes ball and re-pulses start during LED1,
  // hold keeps start asserted so the next call begins back-to-back.
  task automatic run_frame(input logic [8:0] b, input logic [8:0] p1, input logic [8:0] p2,
                           input logic [8:0] p3, input bit disturb, input bit hold);
    logic [23:0] exp_pix [N];
    logic [23:0] got;
    int busy_cnt, fd_cnt, bad, hc, low_cnt;
    bit fell;
    for (int i = 0; i < N; i++) exp_pix[i] = ref_pixel(i, b, p1, p2, p3);
    ball = b; player1 = p1; player2 = p2; player3 = p3;
    start = 1'b1;
    busy_cnt = 0; fd_cnt = 0;
    for (int led = 0; led < N; led++) begin
      got = '0; bad = 0;
      for (int bit_i = 23; bit_i >= 0; bit_i--) begin
        hc = 0; fell = 1'b0;
        for (int c = 0; c < TBIT; c++) begin
          @(negedge clk);
          if (busy === 1'b1) busy_cnt++;
          if (frame_done !== 1'b0) fd_cnt++;
          if (dout === 1'b1) begin
            hc++;
            if (fell) bad++;
          end else begin
            fell = 1'b1;
          end
          if (!hold) start = 1'b0;
          if (disturb && led == 1 && bit_i == 18 && c == 0) begin
            ball = 9'd0;
            start = 1'b1;
          end
        end
        if (hc == T1H) got[bit_i] = 1'b1;
        else if (hc != T0H) bad++;
      end
      chk($sformatf("pixel%0d", led), {8'h0, got}, {8'h0, exp_pix[led]});
      chk($sformatf("shape%0d", led), bad, 0);
    end
    low_cnt = 0;
    for (int c = 0; c < TRESET; c++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (frame_done !== 1'b0) fd_cnt++;
      if (dout === 1'b0 && busy === 1'b1) low_cnt++;
    end
    chk("latch_low", low_cnt, TRESET);
    chk("busy_len", busy_cnt, N * 24 * TBIT + TRESET);
    chk("no_early_done", fd_cnt, 0);
    @(negedge clk);
    chk("done_cycle", {29'h0, busy, dout, frame_done}, 32'h1);
    if (!hold) begin
      start = 1'b0;
      fd_cnt = 0; busy_cnt = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (frame_done !== 1'b0) fd_cnt++;
        if (busy !== 1'b0 || dout !== 1'b0) busy_cnt++;
      end
      chk("single_done", fd_cnt, 0);
      chk("stays_idle", busy_cnt, 0);
    end
  endtask

  initial begin
    int bad;
    // Reset held with start asserted must never launch a frame.
    reset = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset%0d", i), {29'h0, dout, busy, frame_done}, 32'h0);
    end
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("idle", {29'h0, dout, busy, frame_done}, 32'h0);

    run_frame(9'd1, 9'd2, 9'd3, 9'd9, 1'b0, 1'b0);
    run_frame(9'd1, 9'd2, 9'd3, 9'd9, 1'b1, 1'b0);
    run_frame(9'd2, 9'd2, 9'd3, 9'd9, 1'b0, 1'b0);
    run_frame(9'd400, 9'd0, 9'd3, 9'd3, 1'b0, 1'b0);

    // Abort mid-LED2, then confirm a clean frame afterwards.
    ball = 9'd1; player1 = 9'd2; player2 = 9'd3; player3 = 9'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2 * 24 * TBIT + 4) @(negedge clk);
    chk("abort_busy_before", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_outputs", {29'h0, dout, busy, frame_done}, 32'h0);
    reset = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (dout !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    chk("abort_quiet", bad, 0);
    run_frame(9'd1, 9'd2, 9'd3, 9'd9, 1'b0, 1'b0);

    // Back-to-back frames with start held high.
    run_frame(9'd3, 9'd0, 9'd1, 9'd2, 1'b0, 1'b1);
    run_frame(9'd0, 9'd3, 9'd3, 9'd3, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      run_frame(9'($urandom_range(0, 5)), 9'($urandom_range(0, 5)),
                9'($urandom_range(0, 5)), 9'($urandom_range(0, 511)), 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
